// File: rtl/oldland_bus_arb_if.sv
// Bus bundle for the oldland instruction/data arbiter.
// The "master" modport is the arbiter's view: it serves the CPU-side
// instruction and data ports and drives the single memory-side request.
// The "slave" modport is the complementary view used by whatever sits
// around the arbiter (the two requesters plus the memory).
interface oldland_bus_arb_if;
    // Instruction port
    logic        i_access;
    logic [29:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_error;

    // Data port
    logic        d_access;
    logic [29:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;

    // Memory side
    logic        m_access;
    logic [29:0] m_addr;
    logic [3:0]  m_bytesel;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;

    modport master (
        input  i_access, i_addr,
        output i_data, i_ack, i_error,
        input  d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        output d_data, d_ack, d_error,
        output m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
        input  m_data, m_ack, m_error
    );

    modport slave (
        output i_access, i_addr,
        input  i_data, i_ack, i_error,
        output d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        input  d_data, d_ack, d_error,
        input  m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
        output m_data, m_ack, m_error
    );
endinterface

// File: rtl/oldland_bus_arb.sv
// oldland_bus_arb: two-port (instruction / data) arbiter in front of a single
// memory bus. One transfer per grant; when both ports request together the
// port that was not granted last wins. Arbitration costs one idle cycle.
//
// Optional feature: define OLDLAND_BUS_TIMEOUT_EN to abort a grant with an
// error pulse after bus_timeout cycles without m_ack/m_error. Without it a
// grant waits indefinitely for the memory.
module oldland_bus_arb #(
    parameter logic [15:0] bus_timeout = 16'd1024
) (
    input  logic           clk,
    input  logic           rst_n,
    oldland_bus_arb_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant_d;       // 1: data port owned the previous grant
    logic   last_grant_d_next;

    logic   response;           // memory answered this cycle
    logic   timeout_hit;        // grant expired without an answer
    logic   done;               // grant ends this cycle
    logic   fail;               // grant ends with an error

    assign response = bus.m_ack | bus.m_error;

`ifdef OLDLAND_BUS_TIMEOUT_EN
    logic [15:0] timeout_count;

    // Count grant cycles; parked at zero while idle so every grant starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_count <= '0;
        end else if (state == IDLE) begin
            timeout_count <= '0;
        end else begin
            timeout_count <= timeout_count + 16'd1;
        end
    end

    // A real memory response in the final cycle still takes precedence.
    assign timeout_hit = (state != IDLE) && !response &&
                         (timeout_count == bus_timeout - 16'd1);
`else
    // Timeout disabled: the parameter stays for a uniform instantiation.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^bus_timeout;
    assign timeout_hit = 1'b0;
`endif

    assign done = response | timeout_hit;
    // Error wins over ack when the memory raises both.
    assign fail = bus.m_error | timeout_hit;

    // State and fairness register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state        <= state_next;
            last_grant_d <= last_grant_d_next;
        end
    end

    // Arbitration, memory request mux and response routing.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_next        = state;
        last_grant_d_next = last_grant_d;
        bus.m_access      = 1'b0;
        bus.m_addr        = '0;
        bus.m_bytesel     = '0;
        bus.m_wr_en       = 1'b0;
        bus.m_wr_val      = '0;
        bus.i_data        = bus.m_data;
        bus.d_data        = bus.m_data;
        bus.i_ack         = 1'b0;
        bus.i_error       = 1'b0;
        bus.d_ack         = 1'b0;
        bus.d_error       = 1'b0;

        unique case (state)
            IDLE: begin
                // Memory responses arriving here belong to nobody.
                if (bus.i_access && bus.d_access) begin
                    state_next = last_grant_d ? GNT_I : GNT_D;
                end else if (bus.d_access) begin
                    state_next = GNT_D;
                end else if (bus.i_access) begin
                    state_next = GNT_I;
                end
            end

            GNT_I: begin
                bus.m_access  = 1'b1;
                bus.m_addr    = bus.i_addr;
                bus.m_bytesel = 4'b1111;
                if (done) begin
                    // A requester that withdrew still lets the transfer
                    // finish, but gets no pulse for it.
                    bus.i_ack         = bus.i_access & ~fail;
                    bus.i_error       = bus.i_access & fail;
                    state_next        = IDLE;
                    last_grant_d_next = 1'b0;
                end
            end

            GNT_D: begin
                bus.m_access  = 1'b1;
                bus.m_addr    = bus.d_addr;
                bus.m_bytesel = bus.d_bytesel;
                bus.m_wr_en   = bus.d_wr_en;
                bus.m_wr_val  = bus.d_wr_val;
                if (done) begin
                    bus.d_ack         = bus.d_access & ~fail;
                    bus.d_error       = bus.d_access & fail;
                    state_next        = IDLE;
                    last_grant_d_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oldland_bus_arb.sv
// Self-checking bench for oldland_bus_arb: a table of single-cycle vectors,
// hand-written multi-cycle sequences, then random traffic against a
// transaction-level reference model (owner / last owner / wait count).
module tb_oldland_bus_arb;

    localparam logic [15:0] TB_TIMEOUT = 16'd8;
    localparam int NONE   = -1;
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    oldland_bus_arb_if bus ();

    oldland_bus_arb #(.bus_timeout(TB_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic i_acc;
        logic d_acc;
        logic m_ack;
        logic m_err;
        logic e_macc;
        int   e_sel;
        logic e_iack;
        logic e_ierr;
        logic e_dack;
        logic e_derr;
    } vec_t;

    vec_t vecs [14];

    // Reference model state: who owns the bus, who owned it last, and how
    // many unanswered cycles the current owner has waited.
    int mdl_owner;
    int mdl_last;
    int mdl_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctl_now();
        return {bus.m_access, bus.m_wr_en, bus.m_bytesel,
                bus.i_ack, bus.i_error, bus.d_ack, bus.d_error};
    endfunction

    task automatic clear_inputs();
        bus.i_access  = 1'b0;
        bus.i_addr    = '0;
        bus.d_access  = 1'b0;
        bus.d_addr    = '0;
        bus.d_bytesel = '0;
        bus.d_wr_en   = 1'b0;
        bus.d_wr_val  = '0;
        bus.m_data    = '0;
        bus.m_ack     = 1'b0;
        bus.m_error   = 1'b0;
    endtask

    task automatic model_reset();
        mdl_owner = NONE;
        mdl_last  = PORT_D;
        mdl_wait  = 0;
    endtask

    // Returns after releasing reset on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("reset_outputs", 64'(ctl_now()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_grant(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (bus.m_access) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_grant_wait"}, 64'(ok), 64'd1);
    endtask

    // One cycle of the reference model: expected outputs for the current
    // inputs, then advance to the next cycle.
    task automatic model_cycle(output logic [9:0] ctl, output logic [61:0] busv,
                               output bit i_fin, output bit d_fin);
        bit          granted;
        bit          resp;
        bit          tmo;
        bit          fin;
        bit          bad;
        logic [3:0]  bsel;
        logic        wr;
        logic [29:0] a;
        logic [31:0] v;
        granted = (mdl_owner != NONE);
        resp    = bus.m_ack || bus.m_error;
        tmo     = 1'b0;
`ifdef OLDLAND_BUS_TIMEOUT_EN
        tmo = granted && !resp && (mdl_wait == int'(TB_TIMEOUT) - 1);
`endif
        fin  = granted && (resp || tmo);
        bad  = bus.m_error || tmo;
        bsel = '0;
        wr   = 1'b0;
        a    = '0;
        v    = '0;
        if (mdl_owner == PORT_I) begin
            a    = bus.i_addr;
            bsel = 4'b1111;
        end else if (mdl_owner == PORT_D) begin
            a    = bus.d_addr;
            bsel = bus.d_bytesel;
            wr   = bus.d_wr_en;
            v    = bus.d_wr_val;
        end
        i_fin = (mdl_owner == PORT_I) && fin && bus.i_access;
        d_fin = (mdl_owner == PORT_D) && fin && bus.d_access;
        ctl   = {granted, wr, bsel, i_fin && !bad, i_fin && bad, d_fin && !bad, d_fin && bad};
        busv  = {a, v};

        if (granted) begin
            if (fin) begin
                mdl_last  = mdl_owner;
                mdl_owner = NONE;
            end else begin
                mdl_wait++;
            end
        end else begin
            if (bus.i_access && bus.d_access) begin
                mdl_owner = (mdl_last == PORT_D) ? PORT_I : PORT_D;
            end else if (bus.d_access) begin
                mdl_owner = PORT_D;
            end else if (bus.i_access) begin
                mdl_owner = PORT_I;
            end
            mdl_wait = 0;
        end
    endtask

    initial begin
        logic [9:0]  e_ctl;
        logic [61:0] e_bus;
        logic [29:0] e_addr;
        logic [3:0]  e_bsel;
        logic        e_wr;
        logic [31:0] e_val;
        bit          fi;
        bit          fd;
        bit          pi;
        bit          pd;
        int          got [$];
        int          high;

        clear_inputs();

        // i_acc d_acc m_ack m_err | m_access sel i_ack i_err d_ack d_err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, PORT_I, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, PORT_D, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PORT_D, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, PORT_D, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, PORT_I, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, PORT_D, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PORT_I, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- table-driven vectors ----------------
        do_reset();
        bus.i_addr    = 30'h0000_1234;
        bus.d_addr    = 30'h0000_abcd;
        bus.d_bytesel = 4'b0011;
        bus.d_wr_en   = 1'b1;
        bus.d_wr_val  = 32'hcafe_f00d;
        bus.m_data    = 32'h5555_aaaa;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            bus.i_access = vecs[k].i_acc;
            bus.d_access = vecs[k].d_acc;
            bus.m_ack    = vecs[k].m_ack;
            bus.m_error  = vecs[k].m_err;
            #1;
            e_addr = '0;
            e_bsel = '0;
            e_wr   = 1'b0;
            e_val  = '0;
            if (vecs[k].e_sel == PORT_I) begin
                e_addr = 30'h0000_1234;
                e_bsel = 4'b1111;
            end else if (vecs[k].e_sel == PORT_D) begin
                e_addr = 30'h0000_abcd;
                e_bsel = 4'b0011;
                e_wr   = 1'b1;
                e_val  = 32'hcafe_f00d;
            end
            e_ctl = {vecs[k].e_macc, e_wr, e_bsel, vecs[k].e_iack, vecs[k].e_ierr,
                     vecs[k].e_dack, vecs[k].e_derr};
            check($sformatf("vec%0d_ctl", k), 64'(ctl_now()), 64'(e_ctl));
            check($sformatf("vec%0d_bus", k), 64'({bus.m_addr, bus.m_wr_val}), 64'({e_addr, e_val}));
        end
        check("i_data_passthrough", 64'(bus.i_data), 64'h5555_aaaa);
        check("d_data_passthrough", 64'(bus.d_data), 64'h5555_aaaa);

        // ---------------- single data read, ack 3 cycles after m_access ----------------
        do_reset();
        bus.d_addr    = 30'h0000_c0de;
        bus.d_bytesel = 4'b1111;
        bus.d_wr_en   = 1'b0;
        bus.d_access  = 1'b1;
        wait_grant("dread", 5);
        check("dread_addr", 64'(bus.m_addr), 64'h0000_c0de);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("dread_wait%0d_dack", c), 64'(bus.d_ack), 64'd0);
        end
        @(negedge clk);
        bus.m_ack  = 1'b1;
        bus.m_data = 32'hdead_beef;
        #1;
        check("dread_dack", 64'(bus.d_ack), 64'd1);
        check("dread_ddata", 64'(bus.d_data), 64'hdead_beef);
        check("dread_iack", 64'(bus.i_ack), 64'd0);
        @(negedge clk);
        bus.m_ack    = 1'b0;
        bus.d_access = 1'b0;
        #1;
        check("dread_after_ctl", 64'(ctl_now()), 64'd0);

        // ---------------- simultaneous requests after reset ----------------
        do_reset();
        bus.i_addr   = 30'h0000_0111;
        bus.d_addr   = 30'h0000_0222;
        bus.d_bytesel = 4'b1111;
        bus.i_access = 1'b1;
        bus.d_access = 1'b1;
        bus.m_ack    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 2) bus.i_access = 1'b0;
            #1;
            check($sformatf("both_c%0d_macc", c), 64'(bus.m_access), 64'(c % 2));
            if (c == 1) begin
                check("both_first_addr", 64'(bus.m_addr), 64'h0000_0111);
                check("both_first_iack", 64'(bus.i_ack), 64'd1);
            end
            if (c == 3) begin
                check("both_second_addr", 64'(bus.m_addr), 64'h0000_0222);
                check("both_second_dack", 64'(bus.d_ack), 64'd1);
            end
        end
        @(negedge clk);
        clear_inputs();

        // ---------------- both held continuously: strict alternation ----------------
        do_reset();
        bus.i_addr   = 30'h0000_0aaa;
        bus.d_addr   = 30'h0000_0bbb;
        bus.i_access = 1'b1;
        bus.d_access = 1'b1;
        bus.m_ack    = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.m_access) got.push_back((bus.m_addr == 30'h0000_0aaa) ? PORT_I : PORT_D);
        end
        check("alt_grant_count", 64'(got.size()), 64'd6);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("alt_grant%0d", k), 64'(got[k]), 64'((k % 2 == 0) ? PORT_I : PORT_D));
        end
        @(negedge clk);
        clear_inputs();

        // ---------------- reset in the middle of an instruction transfer ----------------
        do_reset();
        bus.i_addr   = 30'h0000_3333;
        bus.i_access = 1'b1;
        wait_grant("midrst", 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_macc_async", 64'(bus.m_access), 64'd0);
        bus.i_access = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("midrst_late_ack%0d", c), 64'(ctl_now()), 64'd0);
            @(negedge clk);
        end
        bus.m_ack = 1'b0;

        // ---------------- grant on first edge after reset release ----------------
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.d_addr   = 30'h0000_4444;
        bus.d_access = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_macc", 64'(bus.m_access), 64'd1);
        check("first_edge_addr", 64'(bus.m_addr), 64'h0000_4444);
        bus.m_ack = 1'b1;
        #1;
        check("first_edge_dack", 64'(bus.d_ack), 64'd1);
        @(negedge clk);
        clear_inputs();

        // ---------------- memory never answers ----------------
        do_reset();
        bus.i_addr   = 30'h0000_5555;
        bus.i_access = 1'b1;
        wait_grant("noack", 5);
`ifdef OLDLAND_BUS_TIMEOUT_EN
        for (int g = 1; g <= 8; g++) begin
            if (g > 1) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("tmo_cycle%0d_ierr", g), 64'(bus.i_error), 64'(g == 8));
        end
        @(negedge clk);
        bus.i_access = 1'b0;
        #1;
        check("tmo_after_macc", 64'(bus.m_access), 64'd0);
        check("tmo_after_ierr", 64'(bus.i_error), 64'd0);
`else
        high = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            #1;
            if (bus.m_access && !bus.i_error) high++;
        end
        check("noack_macc_held", 64'(high), 64'd120);
        bus.m_ack = 1'b1;
        #1;
        check("noack_late_iack", 64'(bus.i_ack), 64'd1);
`endif
        @(negedge clk);
        clear_inputs();

        // ---------------- random traffic against the reference model ----------------
        do_reset();
        pi = 1'b0;
        pd = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.i_access) begin
                if (pi) begin
                    if ($urandom_range(1, 0) == 1) bus.i_addr = 30'($urandom);
                    else bus.i_access = 1'b0;
                end else if ($urandom_range(31, 0) == 0) begin
                    bus.i_access = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.i_access = 1'b1;
                bus.i_addr   = 30'($urandom);
            end
            if (bus.d_access && !pd) begin
                if ($urandom_range(31, 0) == 0) bus.d_access = 1'b0;
            end else if ((bus.d_access && pd && $urandom_range(1, 0) == 1) ||
                         (!bus.d_access && $urandom_range(2, 0) == 0)) begin
                bus.d_access  = 1'b1;
                bus.d_addr    = 30'($urandom);
                bus.d_bytesel = 4'($urandom);
                bus.d_wr_en   = 1'($urandom);
                bus.d_wr_val  = $urandom;
            end else if (bus.d_access && pd) begin
                bus.d_access = 1'b0;
            end
            bus.m_ack   = ($urandom_range(3, 0) == 0);
            bus.m_error = ($urandom_range(7, 0) == 0);
            bus.m_data  = $urandom;
            #1;
            model_cycle(e_ctl, e_bus, fi, fd);
            check($sformatf("rand%0d_ctl", c), 64'(ctl_now()), 64'(e_ctl));
            check($sformatf("rand%0d_bus", c), 64'({bus.m_addr, bus.m_wr_val}), 64'(e_bus));
            pi = fi;
            pd = fd;
        end
        @(negedge clk);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
